oifs_tx_fifo: RTL

- Byte buffer directly upstream of the OIFS fast-serial transmitter.
- Accepts bytes plus an FT channel-select bit from user logic on a valid/ready write port.
- Presents them first-word-fall-through on a valid/ready read port that the serializer drains one frame at a time.
- Decouples bursty producers from the FSCTS-throttled serial link and reports fill level and overflow for debug LEDs.

---
 rtl/oifs_tx_fifo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/oifs_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : oifs_tx_fifo
//  Description : First-word-fall-through byte FIFO placed in front of the
//                OIFS fast-serial transmitter. Each entry holds one byte
//                plus the FT channel-select bit. It also reports the fill
//                level and a sticky overflow flag for the debug LEDs.
//
//  Ports       : i_clk        system clock (PLL output domain)
//                i_arst       asynchronous active-high reset
//                i_wr_valid   producer has a byte
//                o_wr_ready   FIFO can accept (not full)
//                i_wr_data    byte to send
//                i_wr_chan    FT channel bit (0 = A, 1 = B)
//                o_rd_valid   head entry available (not empty)
//                i_rd_ready   serializer pops the head this cycle
//                o_rd_data    head byte (FWFT)
//                o_rd_chan    head channel bit
//                o_level      occupancy, 0..2**DEPTH_LOG2
//                o_ovf        sticky: write attempted while full
//                i_ovf_clr    synchronous clear of o_ovf
//                o_afull      registered level >= AFULL_THRESH
//                             (only with OIFS_TX_FIFO_AFULL_EN)
//
//  Options     : `define OIFS_TX_FIFO_AFULL_EN adds o_afull/AFULL_THRESH.
//  Revision    : 1.0  initial release
// ============================================================================
module oifs_tx_fifo #(
    parameter int DEPTH_LOG2   = 4
`ifdef OIFS_TX_FIFO_AFULL_EN
  , parameter int AFULL_THRESH = 12
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [7:0]            i_wr_data,
    input  logic                  i_wr_chan,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [7:0]            o_rd_data,
    output logic                  o_rd_chan,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_ovf,
    input  logic                  i_ovf_clr
`ifdef OIFS_TX_FIFO_AFULL_EN
  , output logic                  o_afull
`endif
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_PTR_W = DEPTH_LOG2 + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic                r_ovf;
    logic [8:0]          r_mem [c_DEPTH];

    logic                w_empty;
    logic                w_full;
    logic                w_wr_fire;
    logic                w_rd_fire;
    logic                w_ovf_set;
    logic [c_PTR_W-1:0]  w_level;

    // Flags come only from registered pointers, so there is no combinational
    // path from i_rd_ready to o_wr_ready. A full FIFO refuses a write even
    // when a read fires in the same cycle.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                       (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_wr_fire = i_wr_valid & ~w_full;
    assign w_rd_fire = i_rd_ready & ~w_empty;
    assign w_ovf_set = i_wr_valid & w_full;

    // Modulo-2*depth difference is exactly the occupancy 0..depth
    assign w_level   = r_wr_ptr - r_rd_ptr;

    assign o_wr_ready = ~w_full;
    assign o_rd_valid = ~w_empty;
    assign o_level    = w_level;
    assign o_ovf      = r_ovf;
    assign {o_rd_chan, o_rd_data} = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            // A new overflow wins over a simultaneous clear
            r_ovf <= w_ovf_set | (r_ovf & ~i_ovf_clr);
        end
    end

    // Storage is deliberately left unreset; o_rd_data is meaningless
    // while o_rd_valid is low.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {i_wr_chan, i_wr_data};
        end
    end

`ifdef OIFS_TX_FIFO_AFULL_EN
    logic [c_PTR_W-1:0]  w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]  w_rd_ptr_nxt;
    logic [c_PTR_W-1:0]  w_level_nxt;
    logic                r_afull;

    // Compare the next level so o_afull changes on the same edge as o_level
    assign w_wr_ptr_nxt = w_wr_fire ? (r_wr_ptr + c_PTR_ONE) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd_fire ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;
    assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_afull <= 1'b0;
        end else begin
            r_afull <= (32'(w_level_nxt) >= AFULL_THRESH);
        end
    end

    assign o_afull = r_afull;
`endif

endmodule
`default_nettype wire
